// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FC constants: read FSM state codes, default vector length, ReLU helper
package fc_pkg;

  localparam int FC_IN_DIM = 32;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  function automatic logic [7:0] fc_relu8(input logic [7:0] b);
    return b[7] ? 8'h00 : b;
  endfunction

endpackage

// File: rtl/fc_feature_streamer_if.sv
// rtl/fc_feature_streamer_if.sv - upstream byte stream, FC burst output and status bundle
interface fc_feature_streamer_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       fc_done;
  logic       busy;
  logic       timeout_err;

  modport master (
    output s_data, s_valid, fc_done,
    input  s_ready, m_data, m_valid, busy, timeout_err
  );

  modport slave (
    input  s_data, s_valid, fc_done,
    output s_ready, m_data, m_valid, busy, timeout_err
  );

endinterface

// File: rtl/fc_pingpong_buf.sv
// rtl/fc_pingpong_buf.sv - 2 x IN_DIM x 8 storage, one write port and one registered read port
module fc_pingpong_buf #(
  parameter int IN_DIM = 32
) (
  input  logic                      clk,
  input  logic                      i_wr_bank,
  input  logic [$clog2(IN_DIM)-1:0] i_wr_idx,
  input  logic [7:0]                i_wr_data,
  input  logic                      i_we,
  input  logic                      i_rd_bank,
  input  logic [$clog2(IN_DIM)-1:0] i_rd_idx,
  output logic [7:0]                o_rd_data
);

  // Storage is left unreset; the top gates the read data with its valid flag.
  logic [7:0] r_mem [2][IN_DIM];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_bank][i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fc_feature_streamer.sv
// rtl/fc_feature_streamer.sv - ping-pong feature collector streaming unbroken bursts to the FC unit
// Optional FC_STREAM_RELU_EN: bytes with bit7 set are written as 8'h00.
module fc_feature_streamer
  import fc_pkg::*;
#(
  parameter int IN_DIM       = FC_IN_DIM,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fc_feature_streamer_if.slave   bus
);

  localparam int IW = $clog2(IN_DIM);
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IN_DIM - 1);
  localparam logic [TW-1:0] T_LAST   = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  logic [1:0]    r_state;
  logic [1:0]    r_bank_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_idx;
  logic [IW-1:0] r_rd_idx;
  logic [TW-1:0] r_timer;
  logic          r_m_valid;
  logic          r_timeout_err;

  logic          w_s_ready;
  logic          w_wr_en;
  logic          w_wr_last;
  logic          w_send_done;
  logic [7:0]    w_wr_data;
  logic [7:0]    w_rd_data;
  logic [IW-1:0] w_rd_addr;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;

  assign w_s_ready   = rst_n & ~r_bank_full[r_wr_bank];
  assign w_wr_en     = bus.s_valid & w_s_ready;
  assign w_wr_last   = (r_wr_idx == LAST_IDX);
  assign w_send_done = (r_state == SEND) && (r_rd_idx == LAST_IDX);

`ifdef FC_STREAM_RELU_EN
  assign w_wr_data = fc_relu8(bus.s_data);
`else
  assign w_wr_data = bus.s_data;
`endif

  // Read address runs one word ahead so the registered read port lines up with m_valid.
  assign w_rd_addr = (r_state == SEND) ? r_rd_idx + 1'b1 : '0;

  assign w_set = (w_wr_en && w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr = w_send_done ? (2'b01 << r_rd_bank) : 2'b00;

  fc_pingpong_buf #(.IN_DIM(IN_DIM)) u_buf (
    .clk       (clk),
    .i_wr_bank (r_wr_bank),
    .i_wr_idx  (r_wr_idx),
    .i_wr_data (w_wr_data),
    .i_we      (w_wr_en),
    .i_rd_bank (r_rd_bank),
    .i_rd_idx  (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
    end else begin
      if (w_wr_en) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rd_bank     <= 1'b0;
      r_rd_idx      <= '0;
      r_timer       <= '0;
      r_m_valid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state   <= SEND;
            r_m_valid <= 1'b1;
            r_rd_idx  <= '0;
          end
        end
        SEND: begin
          if (r_rd_idx == LAST_IDX) begin
            r_state   <= WAIT_DONE;
            r_m_valid <= 1'b0;
            r_rd_bank <= ~r_rd_bank;
            r_timer   <= '0;
          end else begin
            r_rd_idx <= r_rd_idx + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.fc_done) begin
            r_state <= IDLE;
          end else if ((DONE_TIMEOUT > 0) && (r_timer == T_LAST)) begin
            r_state       <= IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_valid ? w_rd_data : 8'h00;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fc_feature_streamer.sv
// tb/tb_fc_feature_streamer.sv - directed self-checking bench for fc_feature_streamer
module tb_fc_feature_streamer;
  import fc_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_feature_streamer_if bus();

  fc_feature_streamer #(.IN_DIM(N), .DONE_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;
  int first_stall = -1;
  int stall64 = 0;
  int cyc;
  logic [7:0] src  [96];
  logic [7:0] expv [96];

  always @(negedge clk) begin
    if (rst_n && bus.timeout_err) to_cnt <= to_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int   waited;
      logic acc;
      waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = src[i];
      do begin
        acc = bus.s_ready;
        if (!acc) begin
          if (first_stall < 0) first_stall = i;
          if (i == 64) stall64++;
        end
        step();
        waited++;
      end while (!acc && waited < 500);
      if (!acc) chk("feed_accept", acc, 1);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic expect_burst(input string tag, input int first);
    int w;
    w = 0;
    while (!bus.m_valid && w < 300) begin
      step();
      w++;
    end
    chk({tag, "_start"}, bus.m_valid, 1);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_valid"}, bus.m_valid, 1);
      chk({tag, "_data"}, bus.m_data, expv[first + k]);
      step();
    end
    chk({tag, "_end_valid"}, bus.m_valid, 0);
    chk({tag, "_end_data"}, bus.m_data, 0);
    chk({tag, "_busy"}, bus.busy, 1);
  endtask

  task automatic pulse_done();
    repeat (4) step();
    bus.fc_done = 1'b1;
    step();
    bus.fc_done = 1'b0;
    chk("release_busy", bus.busy, 0);
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.fc_done = 1'b0;

    // Reset values
    #12;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    #5 rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", bus.s_ready, 1);

    // fc_done in IDLE is ignored
    bus.fc_done = 1'b1;
    step();
    bus.fc_done = 1'b0;
    chk("idle_done_busy", bus.busy, 0);
    chk("idle_done_valid", bus.m_valid, 0);

    // Test 1: 0..31, one-cycle latency after the last beat
    for (int i = 0; i < N; i++) begin
      src[i] = 8'(i);
      expv[i] = 8'(i);
    end
    feed(0, N);
    chk("t1_latency_pre", bus.m_valid, 0);
    step();
    chk("t1_latency", bus.m_valid, 1);
    chk("t1_busy", bus.busy, 1);
    expect_burst("t1", 0);
    pulse_done();

    // Test 2: 96 continuous beats, fc_done 5 cycles after each burst
    for (int i = 0; i < 96; i++) begin
      src[i] = 8'(i);
      expv[i] = 8'(i);
    end
    first_stall = -1;
    stall64 = 0;
    fork
      feed(0, 96);
      begin
        for (int b = 0; b < 3; b++) begin
          expect_burst("t2", b * N);
          pulse_done();
        end
      end
    join
    chk("t2_first_stall", first_stall, 64);
    chk("t2_stall_cycles", stall64, 1);
    chk("t2_no_timeout", to_cnt, 0);
    chk("t2_s_ready", bus.s_ready, 1);

    // Test 3: no fc_done, timeout after 64 cycles then second vector streams
    for (int i = 0; i < 2 * N; i++) begin
      src[i] = 8'h40 + 8'(i);
      expv[i] = 8'h40 + 8'(i);
    end
    fork
      feed(0, 2 * N);
      begin
        expect_burst("t3a", 0);
        cyc = 0;
        while (!bus.timeout_err && cyc < 200) begin
          step();
          cyc++;
        end
        chk("t3_timeout_cycles", cyc, 64);
        chk("t3_timeout_busy", bus.busy, 0);
        step();
        chk("t3_timeout_pulse", bus.timeout_err, 0);
        chk("t3_next_valid", bus.m_valid, 1);
        expect_burst("t3b", N);
        pulse_done();
      end
    join
    chk("t3_timeout_count", to_cnt, 1);

    // Test 4: reset at burst cycle 10
    for (int i = 0; i < N; i++) begin
      src[i] = 8'h10 + 8'(i);
      src[N + i] = 8'h20 + 8'(i);
      expv[N + i] = 8'h20 + 8'(i);
    end
    feed(0, N);
    step();
    chk("t4_burst_start", bus.m_valid, 1);
    repeat (10) step();
    chk("t4_cycle10_data", bus.m_data, 8'h1A);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", bus.m_valid, 0);
    chk("t4_rst_data", bus.m_data, 0);
    chk("t4_rst_busy", bus.busy, 0);
    chk("t4_rst_s_ready", bus.s_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("t4_rel_s_ready", bus.s_ready, 1);
    chk("t4_rel_valid", bus.m_valid, 0);
    feed(N, N);
    step();
    chk("t4_latency", bus.m_valid, 1);
    expect_burst("t4", N);
    pulse_done();

    // Test 5: sign-bit bytes on the write path
    for (int i = 0; i < N; i++) begin
      src[i] = 8'(i);
      expv[i] = 8'(i);
    end
    src[0] = 8'hF0;
    src[1] = 8'h80;
    src[2] = 8'h7F;
    expv[2] = 8'h7F;
`ifdef FC_STREAM_RELU_EN
    expv[0] = 8'h00;
    expv[1] = 8'h00;
`else
    expv[0] = 8'hF0;
    expv[1] = 8'h80;
`endif
    feed(0, N);
    expect_burst("t5", 0);
    pulse_done();
    chk("final_timeouts", to_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
